// File: rtl/fnd_pkg.sv
// fnd_pkg: segment constants and hex glyph encoder shared by the FND scan driver.
package fnd_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
    return GLYPH[nibble];
  endfunction
endpackage

// File: rtl/fnd_scan_controller_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, sticky overflow on BCD MSB carry-out.
module bin2bcd_seq #(
  parameter int VAL_W = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VAL_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VAL_W);
  logic          busy_q, busy_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] sh_q, sh_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  // The first iteration happens at start: adjusting an all-zero BCD is a no-op.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    busy_d = busy_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d = CW'(VAL_W - 1);
      sh_d = bin << 1;
      bcd_d = BW'(bin[VAL_W-1]);
      ovf_d = 1'b0;
    end else if (busy_q) begin
      busy_d = cnt_q != '0;
      cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
      sh_d = cnt_q != '0 ? sh_q << 1 : sh_q;
      bcd_d = cnt_q != '0 ? {adj[BW-2:0], sh_q[VAL_W-1]} : bcd_q;
      ovf_d = cnt_q != '0 ? ovf_q | adj[BW-1] : ovf_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      sh_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = busy_q;
  assign done = busy_q && cnt_q == '0;
  assign bcd = bcd_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: multiplexed 7-segment driver with decimal/hex load, pending slot,
// tear-free display register, leading-zero blanking, decimal points and overflow dash.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int SCAN_HZ = 1_000,
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VAL_W-1:0]      value,
  input  logic                  value_valid,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic [7:0]            fnd_data,
  output logic [NUM_DIGITS-1:0] fnd_com
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int DW = $clog2(DIV);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int XW = VAL_W > BW ? VAL_W : BW;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_v_q, pend_v_d, pend_hex_q, pend_hex_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d, src_val;
  logic [BW-1:0]         dig_q, dig_d, upper, cv_bcd;
  logic                  ovf_q, ovf_d;
  logic [7:0]            data_q, data_d, seg;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic [XW-1:0]         ext;
  logic                  tick, take, go, src_hex, cv_start, cv_busy, cv_done, cv_ovf;
  bin2bcd_seq #(.VAL_W(VAL_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk), .rst(rst), .start(cv_start), .bin(src_val),
    .busy(cv_busy), .done(cv_done), .bcd(cv_bcd), .ovf(cv_ovf)
  );
  // A waiting pending entry always has priority; a strobe that cannot start refills the slot.
  always_comb begin
    tick = div_q == DW'(DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = !tick ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
    take = value_valid && !cv_busy && !pend_v_q;
    go = take || (pend_v_q && !cv_busy);
    src_hex = pend_v_q ? pend_hex_q : hex_mode;
    src_val = pend_v_q ? pend_val_q : value;
    ext = XW'(src_val);
    cv_start = go && !src_hex;
    pend_v_d = (value_valid && !take) || (pend_v_q && !go);
    pend_val_d = value_valid && !take ? value : pend_val_q;
    pend_hex_d = value_valid && !take ? hex_mode : pend_hex_q;
    dig_d = cv_done ? cv_bcd : go && src_hex ? ext[BW-1:0] : dig_q;
    ovf_d = cv_done ? cv_ovf : go && src_hex ? (ext >> BW) != '0 : ovf_q;
    upper = dig_q >> {idx_q, 2'b00};
    seg = ovf_q ? SEG_DASH : blank_lz && idx_q != '0 && upper == '0 ? SEG_BLANK : seg_encode(upper[3:0]);
    data_d = tick ? {seg[7] & ~dp_mask[idx_q], seg[6:0]} : data_q;
    com_d = tick ? ~(NUM_DIGITS'(1) << idx_q) : com_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      pend_v_q <= 1'b0;
      pend_hex_q <= 1'b0;
      pend_val_q <= '0;
      dig_q <= '0;
      ovf_q <= 1'b0;
      data_q <= SEG_BLANK;
      com_q <= '1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      pend_v_q <= pend_v_d;
      pend_hex_q <= pend_hex_d;
      pend_val_q <= pend_val_d;
      dig_q <= dig_d;
      ovf_q <= ovf_d;
      data_q <= data_d;
      com_q <= com_d;
    end
  end
  assign busy = cv_busy;
  assign fnd_data = data_q;
  assign fnd_com = com_q;
endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Parametrised multiplexed 7-segment (FND) display driver, successor to the fixed 4-digit decimal controller. It converts a binary value to digits with a sequential double-dabble converter, or uses raw nibbles in hex mode, then latches the result into a tear-free display register. Digit count, value width and scan rate are parameters, and the block adds leading-zero blanking, per-digit decimal points and overflow indication. It sits between a status or counter source (timer slave, register bank) and the board's FND pins.

## Interface
- CLK_HZ, 100_000_000: clk frequency.
- SCAN_HZ, 1_000: per-digit scan rate. Divider is CLK_HZ/SCAN_HZ and must be ≥ 2.
- NUM_DIGITS, 4: number of digits, 1..8.
- VAL_W, 14: input value width, ≥ 4.
- clk  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- value  in  VAL_W: binary value to display.
- value_valid  in  1: load strobe, one cycle.
- hex_mode  in  1: 1 = hex digits, 0 = decimal. Sampled together with value_valid.
- blank_lz  in  1: 1 = blank leading zeros. Applied live.
- dp_mask  in  NUM_DIGITS: bit i = 1 lights the decimal point of digit i. Applied live.
- busy  out  1: decimal conversion in progress.
- fnd_data  out  8: active-low segments {dp,g,f,e,d,c,b,a}.
- fnd_com  out  NUM_DIGITS: active-low, strictly one-hot digit enable.

## Operation
- Load in decimal mode:
  - A value_valid with busy=0 captures value and starts the converter.
  - The converter does VAL_W iterations of "add 3 to each BCD nibble ≥5, then shift left".
  - The BCD register is 4·NUM_DIGITS bits. Any 1 shifted out of its MSB sets a sticky overflow flag.
- Load in hex mode: digit i = value[4i+3:4i]. Overflow is set if any value bit ≥ 4·NUM_DIGITS is nonzero.
- value_valid while busy:
  - The value and hex_mode go into a one-entry pending slot. A later strobe overwrites it (last wins).
  - The pending entry starts in the cycle after the current conversion completes.
- On completion, the digits, the overflow flag and the mode are copied atomically into the display register. The display never shows a partial conversion.
- Scan:
  - The tick divider produces a one-cycle tick every CLK_HZ/SCAN_HZ cycles.
  - Each tick advances the scan index 0→NUM_DIGITS-1, then wraps to 0.
- Segment encode for the digit under scan, in priority order:
  1. overflow: dash, 8'hBF.
  2. blank_lz=1 and the digit is a leading zero: 8'hFF. Digit 0 is never blanked.
  3. otherwise glyph 0-9 = C0,F9,A4,B0,99,92,82,F8,80,90; A-F = 88,83,C6,A1,86,8E.
- Decimal point: dp_mask[idx]=1 clears bit 7, regardless of blanking or overflow.
- fnd_com = ~(1<<idx).

## Timing
- Reset values:
  - Outputs: fnd_com all 1s, fnd_data 8'hFF, busy 0.
  - Internal: display register 0, overflow 0, scan index 0, divider 0, pending empty.
- First tick after reset: divider reaches its terminal count after CLK_HZ/SCAN_HZ cycles. fnd_com and fnd_data become valid for digit 0 one cycle after that tick.
- fnd_data and fnd_com are registered. Both update in the same cycle, with no glitch between digits.
- Decimal load: value_valid sampled at edge 0; busy=1 from edge 1 through edge VAL_W. The display register updates and busy falls at edge VAL_W+1.
- Hex load: display updates at edge 1. busy stays 0 unless a decimal conversion is active; then the load is queued as pending.
- A completion coincident with a new value_valid: the new value goes to pending, not lost.
- Reset mid-conversion: conversion is aborted, pending is cleared, and all reset values are restored.
- Live inputs (blank_lz, dp_mask) take effect on the next registered output update.

## Structure
- Package fnd_pkg holds:
  - segment constants: SEG_BLANK=8'hFF, SEG_DASH=8'hBF;
  - the 16-entry glyph table;
  - function seg_encode(nibble).
- One sub-module, bin2bcd_seq (parameters VAL_W, NUM_DIGITS). Ports: start, bin, busy, done, bcd, ovf.
- The top level holds the tick divider, scan counter, pending slot, display register and output registers.

## Test plan
Parameters: CLK_HZ=1000, SCAN_HZ=100 (tick every 10 cycles), NUM_DIGITS=4, VAL_W=14.
- Reset, no load:
  - fnd_com=4'b1111 and fnd_data=FF until the first tick.
  - Then the scan sequence is 1110,1101,1011,0111 with data C0 on every digit (blank_lz=0).
- Decimal 1234:
  - busy is high for 14 cycles.
  - The scan then shows digit0..3 = 99,B0,A4,F9.
- Decimal 7 with blank_lz=1 and dp_mask=4'b0010:
  - digit0=F8, digit1=7F, digit2=FF, digit3=FF.
- Decimal 12000: all digits BF. Hex 16'h3FFF with VAL_W=14: digits 8E,8E,8E,B0.
- Strobes during a 0→5 conversion: strobe 5, then strobe 42 and 9999 while busy.
  - 5 is displayed, then 9999. 42 is never displayed.
  - busy stays high for 2×14 cycles, plus the single restart cycle between conversions.
- Reset asserted mid-conversion: display returns to reset values and busy=0 immediately; no stale value appears after release.
